// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module : ex_stage
// Execute stage and EX/MEM register of the 16-bit TSC pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module ex_stage #(
  parameter int WORD     = 16,
  parameter int REG_BITS = 2,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall_in,
  input  logic                id_valid,
  input  logic [WORD-1:0]     id_pc,
  input  logic [WORD-1:0]     id_rs_data,
  input  logic [WORD-1:0]     id_rt_data,
  input  logic [WORD-1:0]     id_imm,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic [1:0]          id_dest_sel,
  input  logic [3:0]          id_alu_op,
  input  logic                id_alu_src,
  input  logic [2:0]          id_br_type,
  input  logic                id_link,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_reg_write,
  input  logic                id_wwd,
  input  logic                id_halt,
  input  logic [1:0]          fwd_a_sel,
  input  logic [1:0]          fwd_b_sel,
  input  logic [WORD-1:0]     fwd_mem_data,
  input  logic [WORD-1:0]     fwd_wb_data,
  output logic                redirect,
  output logic [WORD-1:0]     redirect_pc,
  output logic                ex_valid,
  output logic [WORD-1:0]     ex_result,
  output logic [WORD-1:0]     ex_store_data,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_reg_write,
  output logic [WORD-1:0]     output_port,
  output logic                halted,
  output logic [CNT_BITS-1:0] retire_count
);

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_AND  = 4'd2;
  localparam logic [3:0] c_ALU_ORR  = 4'd3;
  localparam logic [3:0] c_ALU_NOT  = 4'd4;
  localparam logic [3:0] c_ALU_TCP  = 4'd5;
  localparam logic [3:0] c_ALU_SHL  = 4'd6;
  localparam logic [3:0] c_ALU_SHR  = 4'd7;
  localparam logic [3:0] c_ALU_LHI  = 4'd8;
  localparam logic [3:0] c_ALU_PASS = 4'd9;

  localparam logic [2:0] c_BR_BNE = 3'd1;
  localparam logic [2:0] c_BR_BEQ = 3'd2;
  localparam logic [2:0] c_BR_BGZ = 3'd3;
  localparam logic [2:0] c_BR_BLZ = 3'd4;
  localparam logic [2:0] c_BR_JMP = 3'd5;
  localparam logic [2:0] c_BR_JPR = 3'd6;

  logic [WORD-1:0]     w_a, w_bf, w_b, w_alu, w_target;
  logic [REG_BITS-1:0] w_dest;
  logic                w_taken, w_fire;

  logic                r_valid, r_mem_read, r_mem_write, r_reg_write, r_halted;
  logic [WORD-1:0]     r_result, r_store, r_output_port;
  logic [REG_BITS-1:0] r_dest;
  logic [CNT_BITS-1:0] r_retire;

  always_comb begin
    case (fwd_a_sel)
      2'd1:    w_a = fwd_mem_data;
      2'd2:    w_a = fwd_wb_data;
      default: w_a = id_rs_data;
    endcase
    case (fwd_b_sel)
      2'd1:    w_bf = fwd_mem_data;
      2'd2:    w_bf = fwd_wb_data;
      default: w_bf = id_rt_data;
    endcase
    w_b = id_alu_src ? id_imm : w_bf;
  end

  always_comb begin
    w_alu = '0;
    case (id_alu_op)
      c_ALU_ADD:  w_alu = w_a + w_b;
      c_ALU_SUB:  w_alu = w_a - w_b;
      c_ALU_AND:  w_alu = w_a & w_b;
      c_ALU_ORR:  w_alu = w_a | w_b;
      c_ALU_NOT:  w_alu = ~w_a;
      c_ALU_TCP:  w_alu = ~w_a + WORD'(1);
      c_ALU_SHL:  w_alu = w_a << 1;
      c_ALU_SHR:  w_alu = {w_a[WORD-1], w_a[WORD-1:1]};
      c_ALU_LHI:  w_alu = {id_imm[7:0], {(WORD-8){1'b0}}};
      c_ALU_PASS: w_alu = w_b;
      default:    w_alu = '0;
    endcase
  end

  // Conditions compare the forwarded B, never the immediate.
  always_comb begin
    w_taken  = 1'b0;
    w_target = id_pc + id_imm;
    case (id_br_type)
      c_BR_BNE: w_taken = (w_a != w_bf);
      c_BR_BEQ: w_taken = (w_a == w_bf);
      c_BR_BGZ: w_taken = !w_a[WORD-1] && (w_a != '0);
      c_BR_BLZ: w_taken = w_a[WORD-1];
      c_BR_JMP: begin
        w_taken  = 1'b1;
        w_target = {id_pc[WORD-1:12], id_imm[11:0]};
      end
      c_BR_JPR: begin
        w_taken  = 1'b1;
        w_target = w_a;
      end
      default:  w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (id_dest_sel)
      2'd1:    w_dest = id_rd;
      2'd2:    w_dest = REG_BITS'(2);
      default: w_dest = id_rt;
    endcase
  end

  // reset_n in the fire term drops redirect as soon as reset asserts.
  assign w_fire      = id_valid & ~stall_in & ~r_halted & reset_n;
  assign redirect    = w_fire & w_taken;
  assign redirect_pc = redirect ? w_target : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid       <= 1'b0;
      r_result      <= '0;
      r_store       <= '0;
      r_dest        <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_reg_write   <= 1'b0;
      r_output_port <= '0;
      r_halted      <= 1'b0;
      r_retire      <= '0;
    end else if (!stall_in) begin
      r_valid <= w_fire;
      if (w_fire) begin
        r_result    <= id_link ? id_pc : w_alu;
        r_store     <= w_bf;
        r_dest      <= w_dest;
        r_mem_read  <= id_mem_read  & ~id_halt;
        r_mem_write <= id_mem_write & ~id_halt;
        r_reg_write <= id_reg_write & ~id_halt;
        r_retire    <= r_retire + CNT_BITS'(1);
        if (id_wwd)  r_output_port <= w_a;
        if (id_halt) r_halted      <= 1'b1;
      end else begin
        r_result    <= '0;
        r_store     <= '0;
        r_dest      <= '0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        r_reg_write <= 1'b0;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_result     = r_result;
  assign ex_store_data = r_store;
  assign ex_dest       = r_dest;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_reg_write  = r_reg_write;
  assign output_port   = r_output_port;
  assign halted        = r_halted;
  assign retire_count  = r_retire;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_stage
// Directed-vector scoreboard bench for ex_stage.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall_in, id_valid;
  logic [15:0] id_pc, id_rs_data, id_rt_data, id_imm, fwd_mem_data, fwd_wb_data;
  logic [1:0]  id_rt, id_rd, id_dest_sel, fwd_a_sel, fwd_b_sel;
  logic [3:0]  id_alu_op;
  logic [2:0]  id_br_type;
  logic        id_alu_src, id_link, id_mem_read, id_mem_write, id_reg_write, id_wwd, id_halt;
  logic        redirect, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, halted;
  logic [15:0] redirect_pc, ex_result, ex_store_data, output_port, retire_count;
  logic [1:0]  ex_dest;

  always #5 clk = ~clk;

  ex_stage #(.WORD(16), .REG_BITS(2), .CNT_BITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rt(id_rt), .id_rd(id_rd), .id_dest_sel(id_dest_sel), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_br_type(id_br_type), .id_link(id_link),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .id_wwd(id_wwd), .id_halt(id_halt), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .output_port(output_port), .halted(halted), .retire_count(retire_count)
  );

  typedef struct packed {
    logic        stall, valid;
    logic [15:0] pc, rs, rtd, imm;
    logic [1:0]  rt, rd, dsel;
    logic [3:0]  op;
    logic        src;
    logic [2:0]  br;
    logic        link, mr, mw, rw, wwd, halt;
    logic [1:0]  fa, fb;
    logic [15:0] fmem, fwb;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] result, store;
    logic [1:0]  dest;
    logic        mr, mw, rw;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  vec_t v;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t nop();
    vec_t n;
    n = '0;
    return n;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t ex(input logic [15:0] r, input logic [15:0] s, input logic [1:0] d,
                              input logic mr, input logic mw, input logic rw);
    exp_t e;
    e = '{valid: 1'b1, result: r, store: s, dest: d, mr: mr, mw: mw, rw: rw};
    return e;
  endfunction

  function automatic vec_t alu_v(input logic [3:0] op, input logic [15:0] rs,
                                 input logic [15:0] rtd, input logic [15:0] imm, input logic src);
    vec_t n;
    n = '0;
    n.valid = 1'b1; n.op = op; n.rs = rs; n.rtd = rtd; n.imm = imm; n.src = src;
    n.rt = 2'd3; n.rw = 1'b1;
    return n;
  endfunction

  task automatic apply(input vec_t a);
    stall_in = a.stall; id_valid = a.valid; id_pc = a.pc; id_rs_data = a.rs;
    id_rt_data = a.rtd; id_imm = a.imm; id_rt = a.rt; id_rd = a.rd; id_dest_sel = a.dsel;
    id_alu_op = a.op; id_alu_src = a.src; id_br_type = a.br; id_link = a.link;
    id_mem_read = a.mr; id_mem_write = a.mw; id_reg_write = a.rw; id_wwd = a.wwd;
    id_halt = a.halt; fwd_a_sel = a.fa; fwd_b_sel = a.fb; fwd_mem_data = a.fmem;
    fwd_wb_data = a.fwb;
  endtask

  // One instruction per cycle: inputs change at negedge, redirect is checked
  // combinationally, and the EX/MEM expectation is queued unless stalled.
  task automatic drive(input vec_t a, input exp_t e, input logic redir,
                       input logic [15:0] rpc, input string name);
    @(negedge clk);
    apply(a);
    #1;
    chk({name, " redirect"}, 32'(redirect), 32'(redir));
    if (redir) chk({name, " redirect_pc"}, 32'(redirect_pc), 32'(rpc));
    if (!a.stall) q.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " redirect"},      32'(redirect),      0);
    chk({name, " ex_valid"},      32'(ex_valid),      0);
    chk({name, " ex_result"},     32'(ex_result),     0);
    chk({name, " ex_store_data"}, 32'(ex_store_data), 0);
    chk({name, " ex_dest"},       32'(ex_dest),       0);
    chk({name, " ex_ctrl"},       32'({ex_mem_read, ex_mem_write, ex_reg_write}), 0);
    chk({name, " output_port"},   32'(output_port),   0);
    chk({name, " halted"},        32'(halted),        0);
    chk({name, " retire_count"},  32'(retire_count),  0);
  endtask

  task automatic async_reset(input string name);
    reset_n = 1'b0;
    q.delete();
    #1;
    chk_zero(name);
    @(negedge clk);
    apply(nop());
    reset_n = 1'b1;
    q.push_back(bub());
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    apply(nop());
    #2;
    async_reset(name);
  endtask

  always @(posedge clk) begin
    if (reset_n && !stall_in) begin
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: EX/MEM loaded (ex_valid=%0d) with expected queue size 0, required >=1",
                 ex_valid);
      end else begin
        m_e = q.pop_front();
        chk("sb ex_valid",      32'(ex_valid),      32'(m_e.valid));
        chk("sb ex_result",     32'(ex_result),     32'(m_e.result));
        chk("sb ex_store_data", 32'(ex_store_data), 32'(m_e.store));
        chk("sb ex_dest",       32'(ex_dest),       32'(m_e.dest));
        chk("sb ex_mem_read",   32'(ex_mem_read),   32'(m_e.mr));
        chk("sb ex_mem_write",  32'(ex_mem_write),  32'(m_e.mw));
        chk("sb ex_reg_write",  32'(ex_reg_write),  32'(m_e.rw));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    apply(nop());
    do_reset("reset_init");

    // Forwarding and basic ALU
    v = alu_v(4'd0, 16'h0063, 16'h0003, 16'h0, 1'b0);
    v.fa = 2'd1; v.fmem = 16'h0005; v.dsel = 2'd1; v.rd = 2'd2; v.rt = 2'd0;
    drive(v, ex(16'h0008, 16'h0003, 2'd2, 0, 0, 1), 0, 0, "add_fwd_mem");

    v = nop(); v.valid = 1; v.rs = 16'h0001; v.rtd = 16'h0002; v.pc = 16'h0010;
    v.imm = 16'hFFFE; v.br = 3'd1; v.op = 4'd1; v.rt = 2'd1;
    drive(v, ex(16'hFFFF, 16'h0002, 2'd1, 0, 0, 0), 1, 16'h000E, "bne_taken");
    chk("count_after_add", 32'(retire_count), 1);
    v.br = 3'd2;
    drive(v, ex(16'hFFFF, 16'h0002, 2'd1, 0, 0, 0), 0, 0, "beq_not_taken");

    drive(alu_v(4'd2, 16'hF0F0, 16'h1234, 16'h0FF0, 1), ex(16'h00F0, 16'h1234, 3, 0, 0, 1), 0, 0, "and_imm");
    drive(alu_v(4'd3, 16'hF0F0, 16'h0F0F, 16'h0,    0), ex(16'hFFFF, 16'h0F0F, 3, 0, 0, 1), 0, 0, "orr");
    drive(alu_v(4'd4, 16'h00FF, 16'h0,    16'h0,    0), ex(16'hFF00, 16'h0,    3, 0, 0, 1), 0, 0, "not");
    drive(alu_v(4'd5, 16'h0005, 16'h0,    16'h0,    0), ex(16'hFFFB, 16'h0,    3, 0, 0, 1), 0, 0, "tcp");
    drive(alu_v(4'd6, 16'h8001, 16'h0,    16'h0,    0), ex(16'h0002, 16'h0,    3, 0, 0, 1), 0, 0, "shl");
    drive(alu_v(4'd7, 16'h8002, 16'h0,    16'h0,    0), ex(16'hC001, 16'h0,    3, 0, 0, 1), 0, 0, "shr");
    drive(alu_v(4'd8, 16'h5555, 16'h0,    16'h12AB, 1), ex(16'hAB00, 16'h0,    3, 0, 0, 1), 0, 0, "lhi");
    drive(alu_v(4'd9, 16'h5555, 16'h0,    16'h4321, 1), ex(16'h4321, 16'h0,    3, 0, 0, 1), 0, 0, "pass_b");
    drive(alu_v(4'd1, 16'h0003, 16'h0005, 16'h0,    0), ex(16'hFFFE, 16'h0005, 3, 0, 0, 1), 0, 0, "sub_wrap");
    v = alu_v(4'd0, 16'h0001, 16'h0, 16'h0, 0); v.fb = 2'd2; v.fwb = 16'h7777;
    drive(v, ex(16'h7778, 16'h7777, 3, 0, 0, 1), 0, 0, "add_fwd_wb");

    // Jumps and branches
    v = nop(); v.valid = 1; v.br = 3'd5; v.pc = 16'h3005; v.imm = 16'h0123;
    v.link = 1; v.dsel = 2'd2; v.rw = 1;
    drive(v, ex(16'h3005, 16'h0, 2'd2, 0, 0, 1), 1, 16'h3123, "jal");
    v = nop(); v.valid = 1; v.br = 3'd3; v.pc = 16'h0020; v.imm = 16'h0004; v.rs = 16'h7FFF;
    drive(v, ex(16'h7FFF, 16'h0, 0, 0, 0, 0), 1, 16'h0024, "bgz_taken");
    v.rs = 16'h0000;
    drive(v, ex(16'h0000, 16'h0, 0, 0, 0, 0), 0, 0, "bgz_zero");
    v.br = 3'd4; v.rs = 16'h8000;
    drive(v, ex(16'h8000, 16'h0, 0, 0, 0, 0), 1, 16'h0024, "blz_taken");
    v.rs = 16'h0001;
    drive(v, ex(16'h0001, 16'h0, 0, 0, 0, 0), 0, 0, "blz_not_taken");

    // Memory controls
    v = alu_v(4'd0, 16'h0100, 16'hAAAA, 16'h0002, 1); v.rt = 2'd1; v.mr = 1;
    drive(v, ex(16'h0102, 16'hAAAA, 1, 1, 0, 1), 0, 0, "lwd");
    v.mr = 0; v.mw = 1; v.rw = 0;
    drive(v, ex(16'h0102, 16'hAAAA, 1, 0, 1, 0), 0, 0, "swd");

    // Stall holds everything and suppresses the JPR until released
    v = nop(); v.valid = 1; v.br = 3'd6; v.rs = 16'h0040; v.stall = 1;
    drive(v, bub(), 0, 0, "jpr_stall1");
    drive(v, bub(), 0, 0, "jpr_stall2");
    drive(v, bub(), 0, 0, "jpr_stall3");
    v.stall = 0;
    drive(v, ex(16'h0040, 16'h0, 0, 0, 0, 0), 1, 16'h0040, "jpr_release");
    chk("stall_hold ex_result", 32'(ex_result), 32'h0102);
    chk("stall_hold ex_mem_write", 32'(ex_mem_write), 1);
    chk("stall_hold retire_count", 32'(retire_count), 20);
    drive(nop(), bub(), 0, 0, "jpr_once");
    chk("count_after_jpr", 32'(retire_count), 21);

    // Reset while a redirect is being driven
    v = nop(); v.valid = 1; v.br = 3'd6; v.rs = 16'h0077;
    drive(v, ex(16'h0077, 16'h0, 0, 0, 0, 0), 1, 16'h0077, "jpr_pre_reset");
    #2;
    async_reset("reset_mid_redirect");

    // WWD, HLT, then everything ignored
    v = nop(); v.valid = 1; v.wwd = 1; v.rs = 16'hBEEF;
    drive(v, ex(16'hBEEF, 16'h0, 0, 0, 0, 0), 0, 0, "wwd");
    v = nop(); v.valid = 1; v.halt = 1; v.rw = 1;
    drive(v, ex(16'h0, 16'h0, 0, 0, 0, 0), 0, 0, "hlt");
    drive(alu_v(4'd0, 16'h0001, 16'h0001, 16'h0, 0), bub(), 0, 0, "add_after_hlt");
    v = nop(); v.valid = 1; v.br = 3'd5; v.imm = 16'h0055;
    drive(v, bub(), 0, 0, "jmp_after_hlt");
    drive(nop(), bub(), 0, 0, "idle_halted");
    chk("halt output_port", 32'(output_port), 32'hBEEF);
    chk("halt halted", 32'(halted), 1);
    chk("halt retire_count", 32'(retire_count), 2);

    // Reset while stalled with a valid EX/MEM entry
    do_reset("reset_clears_halt");
    v = nop(); v.valid = 1; v.wwd = 1; v.rs = 16'h1111;
    drive(v, ex(16'h1111, 16'h0, 0, 0, 0, 0), 0, 0, "wwd2");
    v = nop(); v.valid = 1; v.br = 3'd6; v.rs = 16'h0040; v.stall = 1;
    drive(v, bub(), 0, 0, "stall_pre_reset");
    chk("pre_reset ex_valid", 32'(ex_valid), 1);
    chk("pre_reset output_port", 32'(output_port), 32'h1111);
    #2;
    async_reset("reset_mid_stall");

    // Counter wrap
    v = nop(); v.valid = 1;
    for (int i = 0; i < 65535; i++) drive(v, ex(16'h0, 16'h0, 0, 0, 0, 0), 0, 0, "wrap_fill");
    drive(v, ex(16'h0, 16'h0, 0, 0, 0, 0), 0, 0, "wrap_last");
    chk("count_max", 32'(retire_count), 32'hFFFF);
    drive(nop(), bub(), 0, 0, "wrap_idle");
    chk("count_wrap", 32'(retire_count), 0);

    @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
